i2s_rx: RTL and testbench
=========================

Name: i2s_rx

Overview:
- I2S slave receiver at the front of the audio datapath.
- Oversamples the external I2S bit clock, word select and serial data on the system clock.
- Deserializes one stereo frame of left then right two's-complement samples.
- Presents both channels in parallel with a single-cycle valid strobe. The EQ engine consumes the upper 16 bits of each channel plus the strobe.

Parameters:
SMPL_W, 24, sample bits per channel, MSB first (must be <= SLOT_W-1)
SLOT_W, 32, sclk periods per channel slot (64 per stereo frame)

Ports:
clk  input  1  system clock (50 MHz; >= 8 clk per I2S_sclk period)
rst_n  input  1  asynchronous active-low reset
I2S_sclk  input  1  external bit clock, asynchronous to clk
I2S_ws  input  1  word select: 0 = left slot, 1 = right slot
I2S_data  input  1  serial data, changes on sclk falling edge
lft_chnnl  output  SMPL_W  last complete left sample, signed
rght_chnnl  output  SMPL_W  last complete right sample, signed
vld  output  1  one-clk pulse when lft_chnnl/rght_chnnl update
frame_err  output  1  one-clk pulse on detected slot-length violation

Interface rules:
- One clock, clk.
- Reset rst_n is asynchronous, active-low. Every flop resets on negedge rst_n.

Behaviour:
- Input synchronization:
  - I2S_sclk, I2S_ws and I2S_data each pass through 2 flops.
  - A third flop on sclk forms a rising-edge detect, sclk_rise.
  - ws and data are sampled only on sclk_rise, so the three inputs are aligned to one sclk edge.
- Slot edge numbering:
  - Edge 0 is the sclk_rise at which the sampled ws first differs from the ws sampled at the previous sclk_rise (the I2S one-bit delay).
  - Edges 1..SMPL_W carry the sample, MSB first.
  - Edges SMPL_W+1..SLOT_W-1 are ignored padding.
  - A 5-bit (clog2 SLOT_W) edge counter tracks the position.
- State machine (states IDLE, LEFT, RIGHT):
  - IDLE → LEFT: on a ws 1→0 transition at sclk_rise. Counter ← 0.
  - LEFT → RIGHT: on a ws 0→1 transition. Counter ← 0.
  - RIGHT → LEFT: on a ws 1→0 transition. Counter ← 0.
  - In IDLE: shift register and counter hold; no vld.
- Capture:
  - In LEFT/RIGHT, at sclk_rise with counter in 1..SMPL_W, data shifts in at the LSB.
  - At counter == SMPL_W in LEFT: shift register → left holding register.
  - At counter == SMPL_W in RIGHT:
    - Held left → lft_chnnl; shift register → rght_chnnl.
    - vld = 1 on the next clk.
- Latency: vld rises exactly 1 clk after the sclk_rise that samples the right LSB. Outputs change only in the same cycle as vld and otherwise hold.
- Counter: increments at each non-transition sclk_rise and saturates at SLOT_W-1.
- Startup: no vld until a full left and right slot have been received after the first ws falling edge. A right slot seen first (no preceding ws fall) is discarded.
- Reset values:
  - lft_chnnl = 0, rght_chnnl = 0, vld = 0, frame_err = 0.
  - State IDLE, counter 0.
  - All synchronizer flops 0.
- Reset mid-frame: the partial frame is dropped and the state returns to IDLE. The next capture requires a fresh ws falling edge.
- Frame-check conditions (with I2S_FRAME_CHK_EN):
  - A ws transition when counter != SLOT_W-1 is an early edge.
  - A sclk_rise at counter == SLOT_W-1 without a ws transition is a late edge.

Optional Feature:
- Macro: I2S_FRAME_CHK_EN.
- Defined:
  - An early or late edge pulses frame_err for 1 clk and forces IDLE.
  - The current frame's vld is suppressed; any in-progress left sample is discarded.
  - Resync proceeds from the next ws falling edge.
- Undefined:
  - Slot length is not enforced; ws transitions alone drive state changes.
  - frame_err is tied to 0.

Decomposition:
- Shared package eq_pkg:
  - Typedef for the state enum {IDLE, LEFT, RIGHT}.
  - Localparams SMPL_W_DEF = 24 and SLOT_W_DEF = 32.
- One natural sub-module: i2s_sync, the 3-flop synchronizer/edge detector. It outputs sclk_rise, ws_s, data_s and is instantiated once.

Test Plan:
- Nominal frame: 3.072 MHz sclk, left = 24'h123456, right = 24'hABCDEF → one vld pulse with lft_chnnl = 24'h123456, rght_chnnl = 24'hABCDEF; vld exactly 1 clk after the right-LSB sclk_rise.
- Startup mid-frame: start stimulus in a right slot with right = 24'h000001 → no vld for that partial frame; first vld carries the following complete left/right pair.
- Padding ignore: drive 1s on data in edges 25..31 of both slots, left = 24'h800000, right = 24'h7FFFFF → outputs exactly 24'h800000 / 24'h7FFFFF.
- Reset mid-frame: assert rst_n low during edge 10 of the left slot → outputs 0, vld 0; after release the next full frame yields correct values with no spurious vld.
- Frame check (I2S_FRAME_CHK_EN defined): ws toggles after 30 sclk in the left slot → one frame_err pulse, no vld for that frame; vld resumes after the next clean frame.
- Back-to-back: 4 consecutive frames with distinct values → exactly 4 vld pulses, spaced 64 sclk periods (±1 clk) apart, each matching the driven data.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and defaults for the audio front end (I2S receiver, EQ engine).
package eq_pkg;

  localparam int unsigned SMPL_W_DEF = 24;
  localparam int unsigned SLOT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_e;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for the I2S pins plus a third sclk flop for
// rising-edge detection; ws/data stay aligned to the sclk edge they accompany.
module i2s_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic ws_i,
  input  logic data_i,
  output logic sclk_rise_o,
  output logic ws_s_o,
  output logic data_s_o
);

  logic [2:0] sclk_q;
  logic [1:0] ws_q;
  logic [1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      ws_q   <= '0;
      data_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      ws_q   <= {ws_q[0], ws_i};
      data_q <= {data_q[0], data_i};
    end
  end

  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign ws_s_o      = ws_q[1];
  assign data_s_o    = data_q[1];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserializes a left/right frame and strobes vld once per frame.
// Optional slot-length checking is enabled with `define I2S_FRAME_CHK_EN.
module i2s_rx
  import eq_pkg::*;
#(
  parameter int unsigned SMPL_W = SMPL_W_DEF,
  parameter int unsigned SLOT_W = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I2S_sclk,
  input  logic              I2S_ws,
  input  logic              I2S_data,
  output logic [SMPL_W-1:0] lft_chnnl,
  output logic [SMPL_W-1:0] rght_chnnl,
  output logic              vld,
  output logic              frame_err
);

  localparam int unsigned       CNT_W    = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_SMPL = CNT_W'(SMPL_W);

  logic sclk_rise;
  logic ws_s;
  logic data_s;

  i2s_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_i     (I2S_sclk),
    .ws_i       (I2S_ws),
    .data_i     (I2S_data),
    .sclk_rise_o(sclk_rise),
    .ws_s_o     (ws_s),
    .data_s_o   (data_s)
  );

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ws_prev_q;
  logic [SMPL_W-1:0]  shift_q;
  logic [SMPL_W-1:0]  left_hold_q;
  logic               left_ok_q;
  logic [SMPL_W-1:0]  lft_q;
  logic [SMPL_W-1:0]  rght_q;
  logic               vld_q;
  logic               ferr_q;

  logic               ws_edge;
  logic               ws_fall;
  logic [CNT_W-1:0]   cnt_inc;
  logic [SMPL_W-1:0]  shift_nxt;
  logic               slot_err;

  assign ws_edge   = ws_s ^ ws_prev_q;
  assign ws_fall   = ws_edge & ~ws_s;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign shift_nxt = {shift_q[SMPL_W-2:0], data_s};

`ifdef I2S_FRAME_CHK_EN
  logic early_edge;
  logic late_edge;
  assign early_edge = ws_edge && (cnt_q != CNT_MAX);
  assign late_edge  = !ws_edge && (cnt_q == CNT_MAX);
  assign slot_err   = (state_q != IDLE) && (early_edge || late_edge);
`else
  assign slot_err   = 1'b0;
`endif

  // cnt_inc is the index of the current edge within the slot; edge 0 is the ws change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ws_prev_q   <= 1'b0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      lft_q       <= '0;
      rght_q      <= '0;
      vld_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      if (sclk_rise) begin
        ws_prev_q <= ws_s;
        if (slot_err) begin
          ferr_q    <= 1'b1;
          state_q   <= IDLE;
          cnt_q     <= '0;
          left_ok_q <= 1'b0;
        end else begin
          case (state_q)
            IDLE: begin
              if (ws_fall) begin
                state_q   <= LEFT;
                cnt_q     <= '0;
                left_ok_q <= 1'b0;
              end
            end
            LEFT, RIGHT: begin
              if (ws_edge) begin
                state_q <= ws_s ? RIGHT : LEFT;
                cnt_q   <= '0;
                if (!ws_s) left_ok_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
                if (cnt_inc <= CNT_SMPL) begin
                  shift_q <= shift_nxt;
                  if (cnt_inc == CNT_SMPL) begin
                    if (state_q == LEFT) begin
                      left_hold_q <= shift_nxt;
                      left_ok_q   <= 1'b1;
                    end else if (left_ok_q) begin
                      lft_q  <= left_hold_q;
                      rght_q <= shift_nxt;
                      vld_q  <= 1'b1;
                    end
                  end
                end
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign lft_chnnl  = lft_q;
  assign rght_chnnl = rght_q;
  assign vld        = vld_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames bit by bit and checks captured samples.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int unsigned SMPL_W = 24;
  localparam int unsigned SLOT_W = 32;
  localparam int HALF = 165;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              I2S_sclk;
  logic              I2S_ws;
  logic              I2S_data;
  logic [SMPL_W-1:0] lft_chnnl;
  logic [SMPL_W-1:0] rght_chnnl;
  logic              vld;
  logic              frame_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lsb_cyc = 0;
  int ferr_cnt = 0;
  logic [SMPL_W-1:0] q_l[$];
  logic [SMPL_W-1:0] q_r[$];
  int q_c[$];

  i2s_rx #(.SMPL_W(SMPL_W), .SLOT_W(SLOT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I2S_sclk  (I2S_sclk),
    .I2S_ws    (I2S_ws),
    .I2S_data  (I2S_data),
    .lft_chnnl (lft_chnnl),
    .rght_chnnl(rght_chnnl),
    .vld       (vld),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (vld) begin
      q_l.push_back(lft_chnnl);
      q_r.push_back(rght_chnnl);
      q_c.push_back(cyc);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sclk_bit(input logic w, input logic d, input bit mark);
    I2S_sclk = 1'b0;
    I2S_ws   = w;
    I2S_data = d;
    #HALF;
    I2S_sclk = 1'b1;
    if (mark) lsb_cyc = cyc;
    #HALF;
  endtask

  task automatic send_slot(input logic w, input logic [SMPL_W-1:0] s, input logic pad, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      logic d;
      d = (k >= 1 && k <= SMPL_W) ? s[SMPL_W-k] : pad;
      sclk_bit(w, d, (w == 1'b1) && (k == SMPL_W));
    end
  endtask

  task automatic send_frame(input logic [SMPL_W-1:0] l, input logic [SMPL_W-1:0] r, input logic pad);
    send_slot(1'b0, l, pad, SLOT_W);
    send_slot(1'b1, r, pad, SLOT_W);
  endtask

  task automatic clear_q();
    q_l.delete();
    q_r.delete();
    q_c.delete();
  endtask

  task automatic settle();
    I2S_sclk = 1'b0;
    repeat (8) @(posedge clk);
    #3;
  endtask

  logic [SMPL_W-1:0] bl[4] = '{24'h111111, 24'hFEDCBA, 24'h000000, 24'h7A5A5A};
  logic [SMPL_W-1:0] br[4] = '{24'h222222, 24'h012345, 24'hFFFFFF, 24'h85A5A5};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f0;
    rst_n    = 1'b0;
    I2S_sclk = 1'b0;
    I2S_ws   = 1'b1;
    I2S_data = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lft", lft_chnnl, 0);
    check("rst_rght", rght_chnnl, 0);
    check("rst_vld", vld, 0);
    check("rst_ferr", frame_err, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #3;

    // startup in a right slot, then a nominal frame
    clear_q();
    send_slot(1'b1, 24'h000001, 1'b0, SLOT_W);
    send_frame(24'h123456, 24'hABCDEF, 1'b0);
    settle();
    check("nom_cnt", q_l.size(), 1);
    if (q_l.size() >= 1) begin
      check("nom_lft", q_l[0], 24'h123456);
      check("nom_rght", q_r[0], 24'hABCDEF);
      check("nom_lat", q_c[0] - lsb_cyc, 3);
    end
    check("nom_hold_lft", lft_chnnl, 24'h123456);
    check("nom_hold_rght", rght_chnnl, 24'hABCDEF);

    // padding ones are ignored
    clear_q();
    send_frame(24'h800000, 24'h7FFFFF, 1'b1);
    settle();
    check("pad_cnt", q_l.size(), 1);
    if (q_l.size() >= 1) begin
      check("pad_lft", q_l[0], 24'h800000);
      check("pad_rght", q_r[0], 24'h7FFFFF);
    end

    // reset in the middle of a left slot
    clear_q();
    send_slot(1'b0, 24'h555555, 1'b0, 11);
    I2S_sclk = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_lft", lft_chnnl, 0);
    check("mrst_rght", rght_chnnl, 0);
    check("mrst_vld", vld, 0);
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #3;
    send_slot(1'b1, 24'h00ABCD, 1'b0, SLOT_W);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    settle();
    check("mrst_cnt", q_l.size(), 1);
    if (q_l.size() >= 1) begin
      check("mrst_lft2", q_l[0], 24'h0F0F0F);
      check("mrst_rght2", q_r[0], 24'hF0F0F0);
    end

    // back-to-back frames
    clear_q();
    for (int i = 0; i < 4; i++) send_frame(bl[i], br[i], 1'b0);
    settle();
    check("b2b_cnt", q_l.size(), 4);
    if (q_l.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("b2b_lft%0d", i), q_l[i], bl[i]);
        check($sformatf("b2b_rght%0d", i), q_r[i], br[i]);
      end
      for (int i = 1; i < 4; i++) begin
        int gap;
        gap = q_c[i] - q_c[i-1];
        check($sformatf("b2b_gap%0d", i), (gap >= 1055 && gap <= 1057), 1);
      end
    end

    // short left slot: ws toggles after 30 sclk
    clear_q();
    f0 = ferr_cnt;
    send_slot(1'b0, 24'h3C3C3C, 1'b0, 30);
    send_slot(1'b1, 24'hC3C3C3, 1'b0, SLOT_W);
    send_frame(24'h13579B, 24'h2468AC, 1'b0);
    settle();
`ifdef I2S_FRAME_CHK_EN
    check("fchk_ferr", ferr_cnt - f0, 1);
    check("fchk_cnt", q_l.size(), 1);
    if (q_l.size() >= 1) begin
      check("fchk_lft", q_l[0], 24'h13579B);
      check("fchk_rght", q_r[0], 24'h2468AC);
    end
    check("ferr_total", ferr_cnt, 1);
`else
    check("short_ferr", ferr_cnt - f0, 0);
    check("short_cnt", q_l.size(), 2);
    if (q_l.size() >= 2) begin
      check("short_lft0", q_l[0], 24'h3C3C3C);
      check("short_rght0", q_r[0], 24'hC3C3C3);
      check("short_lft1", q_l[1], 24'h13579B);
      check("short_rght1", q_r[1], 24'h2468AC);
    end
    check("ferr_total", ferr_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
